// File: rtl/wb_mem_unit.sv
// Memory-access / write-back stage: ALU pass-through, LDR/STR handshake with a data SRAM.
// Optional MEM_TIMEOUT_EN aborts an access after MEM_TIMEOUT busy cycles and sets mem_err.
module wb_mem_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_BASE    = 1024,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              wb_en,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] val_rm,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              WB_WB_EN,
  output logic [3:0]        WB_Dest,
  output logic [DATA_W-1:0] WB_Value,
  output logic              mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic        lat_wb_en;
  logic        lat_load;
  logic [3:0]  lat_dest;
  logic        memop;
  logic        tmo;
  logic        done;

  assign memop = in_valid & (mem_r_en | mem_w_en);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  // Timeout only when the SRAM has not answered in the same cycle.
  assign tmo = (state == BUSY) & ~mem_ready & (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
      if (tmo) mem_err <= 1'b1;
    end
  end
`else
  // No abort path in this build; the term only keeps MEM_TIMEOUT referenced.
  assign tmo     = (MEM_TIMEOUT == 0) & 1'b0;
  assign mem_err = 1'b0;
`endif

  assign done   = mem_ready | tmo;
  assign freeze = (state == IDLE) ? memop : ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_wb_en <= 1'b0;
      lat_load  <= 1'b0;
      lat_dest  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      WB_WB_EN  <= 1'b0;
      WB_Dest   <= '0;
      WB_Value  <= '0;
    end else begin
      WB_WB_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (memop) begin
            lat_wb_en <= wb_en;
            lat_load  <= mem_r_en;
            lat_dest  <= dest;
            mem_req   <= 1'b1;
            mem_we    <= mem_w_en & ~mem_r_en;
            mem_addr  <= (alu_result - DATA_W'(MEM_BASE)) >> 2;
            mem_wdata <= val_rm;
            state     <= BUSY;
          end else if (in_valid) begin
            WB_WB_EN <= wb_en;
            WB_Dest  <= dest;
            WB_Value <= alu_result;
          end
        end
        BUSY: begin
          if (done) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
            // Stores and aborted accesses never pulse the register-file write.
            if (!tmo) begin
              WB_WB_EN <= lat_wb_en & lat_load;
              WB_Dest  <= lat_dest;
              WB_Value <= lat_load ? mem_rdata : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_unit.sv
// Directed bench for wb_mem_unit: a queue of expected write-backs (cycle, dest, value)
// is checked every cycle, plus literal checks on addresses, strobes and data.
module tb_wb_mem_unit;

  localparam int unsigned DW   = 32;
  localparam int unsigned BASE = 1024;
  localparam int unsigned TMO  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          mem_r_en = 1'b0;
  logic          mem_w_en = 1'b0;
  logic          wb_en = 1'b0;
  logic [3:0]    dest = '0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] val_rm = '0;
  logic          freeze;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = 32'hDEADBEEF;
  logic          WB_WB_EN;
  logic [3:0]    WB_Dest;
  logic [DW-1:0] WB_Value;
  logic          mem_err;

  wb_mem_unit #(.DATA_W(DW), .MEM_BASE(BASE), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en(wb_en), .dest(dest), .alu_result(alu_result), .val_rm(val_rm), .freeze(freeze),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest),
    .WB_Value(WB_Value), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [3:0]   d;
    logic [DW-1:0] v;
  } wb_t;

  wb_t           expq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_on = 1'b0;
  bit            exp_req = 1'b0;
  logic [DW-1:0] obs_addr = '0;
  logic [DW-1:0] obs_wdata = '0;
  logic          obs_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expected write-back schedule and request state.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (expq.size() > 0 && expq[0].due == cyc) begin
        chk("wb_en", 32'(WB_WB_EN), 32'd1);
        chk("wb_dest", 32'(WB_Dest), 32'(expq[0].d));
        chk("wb_value", WB_Value, expq[0].v);
        void'(expq.pop_front());
      end else begin
        chk("wb_quiet", 32'(WB_WB_EN), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    wb_en    = 1'b0;
  endtask

  task automatic alu(input logic [3:0] d, input logic [DW-1:0] v, input logic we);
    in_valid = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
    wb_en = we; dest = d; alu_result = v;
    if (we) expq.push_back('{cyc + 1, d, v});
    #1 chk("alu_freeze", 32'(freeze), 32'd0);
    step();
  endtask

  // One LDR/STR: n busy cycles; ready (if rdy) arrives in the last one.
  task automatic mem_op(input logic rd, input logic wr, input logic we, input logic [3:0] d,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input int n, input bit rdy, input logic [DW-1:0] rdata);
    logic [DW-1:0] eaddr;
    eaddr = (addr - BASE) / 4;
    in_valid = 1'b1; mem_r_en = rd; mem_w_en = wr; wb_en = we;
    dest = d; alu_result = addr; val_rm = wdata;
    #1 chk("issue_freeze", 32'(freeze), 32'd1);
    step();
    exp_req = 1'b1;
    for (int k = 1; k <= n; k++) begin
      chk("mem_we", 32'(mem_we), 32'(wr & ~rd));
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_wdata", mem_wdata, wdata);
      obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
      if (k == n && rdy) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
        if (rd && we) expq.push_back('{cyc + 1, d, rdata});
      end
      #1 chk("busy_freeze", 32'(freeze), (k == n) ? 32'd0 : 32'd1);
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'hDEADBEEF;
    end
    exp_req = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_en", 32'(WB_WB_EN), 32'd0);
    chk("rst_wb_dest", 32'(WB_Dest), 32'd0);
    chk("rst_wb_value", WB_Value, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    step(); step();
    rst = 1'b1;
    mon_on = 1'b1;
    step();

    alu(4'd3, 32'h55, 1'b1);
    idle();
    @(negedge clk);
    chk("alu_lit_dest", 32'(WB_Dest), 32'd3);
    chk("alu_lit_value", WB_Value, 32'h55);
    step();
    alu(4'd4, 32'h99, 1'b0);

    mem_op(1'b1, 1'b0, 1'b1, 4'd5, 32'd1032, 32'h0, 4, 1'b1, 32'hCAFEF00D);
    idle();
    chk("ldr_lit_addr", obs_addr, 32'd2);
    chk("ldr_lit_we", 32'(obs_we), 32'd0);
    @(negedge clk);
    chk("ldr_lit_value", WB_Value, 32'hCAFEF00D);
    chk("ldr_lit_dest", 32'(WB_Dest), 32'd5);
    step();

    mem_op(1'b0, 1'b1, 1'b1, 4'd1, 32'd1028, 32'h1234, 1, 1'b1, 32'h0);
    chk("str_lit_addr", obs_addr, 32'd1);
    chk("str_lit_we", 32'(obs_we), 32'd1);
    chk("str_lit_wdata", obs_wdata, 32'h1234);
    alu(4'd6, 32'h77, 1'b1);

    mem_op(1'b1, 1'b0, 1'b1, 4'd8, 32'd1048, 32'h0, 1, 1'b1, 32'h11111111);
    alu(4'd9, 32'h2222, 1'b1);

    mem_op(1'b1, 1'b1, 1'b1, 4'd10, 32'd1100, 32'hAAAA, 2, 1'b1, 32'h3333);
    mem_op(1'b1, 1'b0, 1'b1, 4'd11, 32'd4, 32'h0, 1, 1'b1, 32'h44);
    chk("wrap_lit_addr", obs_addr, 32'h3FFFFF01);
    mem_op(1'b1, 1'b0, 1'b1, 4'd12, 32'd1035, 32'h0, 2, 1'b1, 32'h55AA);
    chk("lowbits_lit_addr", obs_addr, 32'd2);

    idle();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD0BAD;
    step();
    mem_ready = 1'b0;
    step();

`ifdef MEM_TIMEOUT_EN
    mem_op(1'b1, 1'b0, 1'b1, 4'd13, 32'd1060, 32'h0, TMO, 1'b1, 32'h600D);
    chk("late_ready_err", 32'(mem_err), 32'd0);
    mem_op(1'b1, 1'b0, 1'b1, 4'd14, 32'd1064, 32'h0, TMO, 1'b0, 32'h0);
    chk("timeout_err", 32'(mem_err), 32'd1);
    alu(4'd2, 32'hABC, 1'b1);
    idle();
    step();
    chk("timeout_sticky", 32'(mem_err), 32'd1);
`endif

    // Reset in the middle of a load: request drops at once, no write-back follows.
    in_valid = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0; wb_en = 1'b1;
    dest = 4'd7; alu_result = 32'd1040;
    step();
    exp_req = 1'b1;
    step();
    rst = 1'b0;
    idle();
    exp_req = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_wb_en", 32'(WB_WB_EN), 32'd0);
    chk("midrst_freeze", 32'(freeze), 32'd0);
    chk("midrst_mem_err", 32'(mem_err), 32'd0);
    step();
    rst = 1'b1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step(); step();
    alu(4'd15, 32'hF00D, 1'b1);
    idle();
    step(); step();

    chk("queue_drained", 32'(expq.size()), 32'd0);
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mem_unit.md
Name: wb_mem_unit

Overview:
- Memory-access and write-back end of the ARM pipeline; produces the WB_WB_EN / WB_Dest / WB_Value triple that the decode stage consumes to write the register file.
- Accepts one instruction per cycle from the EXE/MEM register and runs a multi-cycle handshake with an external data SRAM for LDR/STR.
- Stalls upstream with freeze while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and address width (matches `ADDRESS_LEN).
- MEM_BASE, 1024, byte address of data memory word 0. Subtracted before word indexing.
- MEM_TIMEOUT, 64, max BUSY cycles before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction valid. Held stable while freeze=1.
- mem_r_en  input  1  load instruction.
- mem_w_en  input  1  store instruction.
- wb_en  input  1  instruction writes a register.
- dest  input  4  destination register.
- alu_result  input  DATA_W  ALU result, or byte address for LDR/STR.
- val_rm  input  DATA_W  store data.
- freeze  output  1  stall upstream (combinational).
- mem_req  output  1  SRAM request (registered).
- mem_we  output  1  SRAM write strobe, valid with mem_req.
- mem_addr  output  DATA_W  SRAM word address.
- mem_wdata  output  DATA_W  SRAM write data.
- mem_ready  input  1  SRAM completion, single-cycle pulse.
- mem_rdata  input  DATA_W  read data, valid with mem_ready.
- WB_WB_EN  output  1  register-file write enable (registered).
- WB_Dest  output  4  write-back register (registered).
- WB_Value  output  DATA_W  write-back data (registered).
- mem_err  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, WB_WB_EN, WB_Dest, WB_Value, mem_err all 0; timeout counter 0. Reset mid-access drops mem_req immediately and discards the access (no WB pulse).
- memop = in_valid & (mem_r_en | mem_w_en). If mem_r_en and mem_w_en are both set, treat as load with mem_we=0.
- IDLE:
  - in_valid & ~memop: next edge WB_WB_EN<=wb_en, WB_Dest<=dest, WB_Value<=alu_result. Latency 1.
  - memop: freeze=1. Next edge: latch dest, wb_en, mem_r_en; mem_req<=1, mem_we<=mem_w_en & ~mem_r_en, mem_addr<=(alu_result-MEM_BASE)>>2, mem_wdata<=val_rm; go to BUSY; WB_WB_EN<=0.
  - ~in_valid: WB_WB_EN<=0.
- Address arithmetic: modulo 2^DATA_W. alu_result < MEM_BASE wraps without error. Low two bits are dropped.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata held constant. freeze = ~mem_ready.
  - On mem_ready: next edge mem_req<=0, state<=IDLE, WB_WB_EN<=latched wb_en, WB_Dest<=latched dest, WB_Value<=mem_rdata for loads (alu_result ignored), 0 for stores.
  - freeze drops in the mem_ready cycle, so upstream advances at that same edge. The next IDLE cycle sees the next instruction; no instruction is executed twice.
- Load total latency: 1 (IDLE) + N (BUSY, including the ready cycle) + WB registered at the exit edge.
- WB_WB_EN is a one-cycle pulse per completed instruction. Never high for stores, bubbles, or aborted accesses.
- mem_ready outside BUSY is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter runs in BUSY and clears on entry to BUSY.
  - When the counter reaches MEM_TIMEOUT-1 without mem_ready, that cycle is treated as completion: freeze=0; next edge mem_req<=0, IDLE, WB_WB_EN<=0, mem_err<=1 (sticky until reset).
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; mem_err tied 0.

Test Plan:
- Reset: assert rst=0 during BUSY -> mem_req=0, WB_WB_EN=0, state IDLE immediately; no WB pulse after release.
- ALU op: dest=3, alu_result=0x55, wb_en=1, no memop -> next cycle WB_WB_EN=1, WB_Dest=3, WB_Value=0x55, freeze never high.
- LDR: alu_result=1032, dest=5, mem_ready after 3 BUSY cycles with mem_rdata=0xCAFEF00D -> mem_addr=2, mem_we=0, freeze high 4 cycles, then one WB pulse: dest 5, value 0xCAFEF00D.
- STR: alu_result=1028, val_rm=0x1234, mem_ready on 1st BUSY cycle -> mem_addr=1, mem_we=1, mem_wdata=0x1234; WB_WB_EN stays 0; following ALU op written back the cycle after.
- Back-to-back LDR then ALU op with mem_ready in the first BUSY cycle -> exactly one WB pulse each, in order, with no duplicated load.
- MEM_TIMEOUT_EN, MEM_TIMEOUT=4, no mem_ready -> mem_req drops after 4 BUSY cycles, mem_err=1, WB_WB_EN=0. Repeat with mem_ready in the 4th cycle -> normal completion, mem_err=0.
